// File: rtl/pia_dsp_uart_tx_pkg.sv
// Shared types and constants for the PIA display-port UART transmitter.
package pia_dsp_uart_tx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_LF = 7'h0A;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_DATA    = 5'b00100,
    S_STOP    = 5'b01000,
    S_RELEASE = 5'b10000
  } state_t;

endpackage

// File: rtl/pia_dsp_uart_tx_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, one-cycle tick on terminal count.
module dsp_baud_gen
  import pia_dsp_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == TERM)) cnt_d = '0;
  end

  assign tick_o = !clear_i && (cnt_q == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pia_dsp_uart_tx.sv
// Apple-1 PIA display-port consumer: 4-phase handshake in, 8N1 UART out.
// Define DSP_UART_CRLF_EN to follow every CR with an automatic LF frame.
module pia_dsp_uart_tx
  import pia_dsp_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dsp_rdy,
  input  logic [6:0] dsp_data,
  output logic       dsp_ack,
  output logic       txd,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
  logic       ack_q, ack_d;
  logic       tick;
  logic       baud_clear;
`ifdef DSP_UART_CRLF_EN
  logic       pending_lf_q, pending_lf_d;
`endif

  // Counter is held at zero whenever no frame is in flight, so the start
  // bit always gets a full bit period from the accepting edge.
  assign baud_clear = (state_q == S_IDLE) || (state_q == S_RELEASE);

  dsp_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear_i(baud_clear),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    ack_d     = ack_q;
`ifdef DSP_UART_CRLF_EN
    pending_lf_d = pending_lf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (dsp_rdy) begin
          shift_d = {1'b0, dsp_data};
          ack_d   = 1'b1;
          txd_d   = 1'b0;
          state_d = S_START;
`ifdef DSP_UART_CRLF_EN
          pending_lf_d = (dsp_data == ASCII_CR);
`endif
        end
      end
      S_START: begin
        if (tick) begin
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
`ifdef DSP_UART_CRLF_EN
          if (pending_lf_q) begin
            pending_lf_d = 1'b0;
            shift_d      = {1'b0, ASCII_LF};
            txd_d        = 1'b0;
            state_d      = S_START;
          end else begin
            ack_d   = 1'b0;
            state_d = S_RELEASE;
          end
`else
          ack_d   = 1'b0;
          state_d = S_RELEASE;
`endif
        end
      end
      S_RELEASE: begin
        if (!dsp_rdy) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      ack_q     <= ack_d;
    end
  end

`ifdef DSP_UART_CRLF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_lf_q <= 1'b0;
    else       pending_lf_q <= pending_lf_d;
  end
`endif

  assign txd     = txd_q;
  assign dsp_ack = ack_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_pia_dsp_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes txd.
module tb_pia_dsp_uart_tx;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       dsp_rdy;
  logic [6:0] dsp_data;
  logic       dsp_ack;
  logic       txd;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  pia_dsp_uart_tx #(
    .CLKS_PER_BIT(N),
    .CNT_W       (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dsp_rdy (dsp_rdy),
    .dsp_data(dsp_data),
    .dsp_ack (dsp_ack),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: samples txd on falling clk edges, mid-bit; abandons on reset.
  initial begin
    int         phase;
    int         cyc;
    logic [7:0] rx;
    logic [7:0] want;
    phase = -1;
    cyc   = 0;
    rx    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = -1;
      end else if (phase < 0) begin
        if (!txd) begin
          phase = 0;
          cyc   = 0;
          rx    = '0;
        end
      end else begin
        cyc++;
        if (cyc == N/2 && txd !== 1'b0) begin
          n_cmp++; n_bad++;
          $display("FAIL start_bit: got %b, required 0", txd);
        end
        for (int i = 0; i < 8; i++)
          if (cyc == int'(N) * (1 + i) + int'(N/2)) rx[i] = txd;
        if (cyc == int'(N) * 9 + int'(N/2)) begin
          check("stop_bit", int'(txd), 1);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame: got 0x%02h, required no frame", rx);
          end else begin
            want = exp_q.pop_front();
            check("frame_byte", int'(rx), int'(want));
          end
          phase = -1;
        end
      end
    end
  end

  task automatic send(input logic [6:0] c, input int rdy_hold, input bit toggle);
    int len;
    int exp_len;
    exp_len = 10 * N;
    @(negedge clk);
    dsp_rdy  = 1'b1;
    dsp_data = c;
    exp_q.push_back({1'b0, c});
`ifdef DSP_UART_CRLF_EN
    if (c == 7'h0D) begin
      exp_q.push_back(8'h0A);
      exp_len = 20 * N;
    end
`endif
    @(posedge clk); #1;
    check("accept_ack", int'(dsp_ack), 1);
    check("accept_txd", int'(txd), 0);
    check("accept_busy", int'(busy), 1);
    len = 0;
    while (dsp_ack && len < 400) begin
      @(posedge clk); #1;
      len++;
      if (toggle && len == 10) dsp_data = 7'h7F;
    end
    check("ack_len", len, exp_len);
    for (int k = 0; k < rdy_hold; k++) begin
      @(negedge clk);
      check("no_reaccept_ack", int'(dsp_ack), 0);
      check("release_busy", int'(busy), 1);
    end
    @(negedge clk);
    dsp_rdy = 1'b0;
    @(posedge clk); #1;
    check("idle_after", int'(busy), 0);
    check("idle_txd", int'(txd), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    dsp_rdy  = 1'b0;
    dsp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_ack", int'(dsp_ack), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle_txd50", int'(txd), 1);
      check("idle_ack50", int'(dsp_ack), 0);
      check("idle_busy50", int'(busy), 0);
    end

    send(7'h41, 3, 1'b0);
    send(7'h42, 0, 1'b0);

    // Abort 0x55 during data bit 3 (accept edge + 17 cycles)
    @(negedge clk);
    dsp_rdy  = 1'b1;
    dsp_data = 7'h55;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_txd", int'(txd), 1);
    check("abort_ack", int'(dsp_ack), 0);
    check("abort_busy", int'(busy), 0);
    dsp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_abort_txd", int'(txd), 1);
      check("post_abort_busy", int'(busy), 0);
    end

    send(7'h30, 0, 1'b1);
    send(7'h0D, 0, 1'b0);
    send(7'h5A, 1, 1'b0);

    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
